// File: rtl/debug_access_unit_if.sv
// Debug access bundle: host request/response channel plus the core
// coprocessor I/O port driven by debug_access_unit.
//   slave  : debug_access_unit side (accepts requests, drives coprocessor I/O)
//   master : host decoder / datapath side
// Signals:
//   req_valid/req_ready/req_cmd/req_addr/req_wdata  request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err           response channel
//   halted                                          core held by debug unit
//   coprocessorIOAddr/Control/DataOut/DataIn        core coprocessor port
`timescale 1ns/1ps
interface debug_access_unit_if #(
    parameter int unsigned N = 64
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_cmd;
    logic [11:0]   req_addr;
    logic [N-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          halted;
    logic [14:0]   coprocessorIOAddr;
    logic [4:0]    coprocessorIOControl;
    logic [N-1:0]  coprocessorIODataOut;
    logic [N-1:0]  coprocessorIODataIn;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
               coprocessorIODataIn,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, halted,
               coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
               coprocessorIODataIn,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, halted,
               coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
    );
endinterface

// File: rtl/debug_access_unit.sv
// Debug access sequencer in front of the core coprocessor I/O port.
// Turns host debug requests (halt/resume, GPR read/write, CSR read) into
// coprocessor control sequences and returns one response per request.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    debug_access_unit_if.slave (request/response + coprocessor port)
// All outputs are registered. halted mirrors control[1] by construction.
`timescale 1ns/1ps
module debug_access_unit #(
    parameter int unsigned N = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    debug_access_unit_if.slave    bus
);

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned IOA_W  = 15;
    localparam int unsigned CTRL_W = 5;

    localparam logic [CMD_W-1:0] CMD_NOP       = 3'd0;
    localparam logic [CMD_W-1:0] CMD_HALT      = 3'd1;
    localparam logic [CMD_W-1:0] CMD_RESUME    = 3'd2;
    localparam logic [CMD_W-1:0] CMD_READ_GPR  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_WRITE_GPR = 3'd4;
    localparam logic [CMD_W-1:0] CMD_READ_CSR  = 3'd5;

    // Control encodings: [0] GPR wr, [1] halt hold, [2] read, [3] CSR sel
    localparam logic [CTRL_W-1:0] CTRL_IDLE     = 5'b00000;
    localparam logic [CTRL_W-1:0] CTRL_HALT     = 5'b00010;
    localparam logic [CTRL_W-1:0] CTRL_RD_GPR   = 5'b00110;
    localparam logic [CTRL_W-1:0] CTRL_RD_CSR   = 5'b01110;
    localparam logic [CTRL_W-1:0] CTRL_WR_GPR   = 5'b00011;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_HALTED  = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t              r_state;
    logic [CMD_W-1:0]    r_cmd;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [N-1:0]        r_rsp_rdata;
    logic                r_rsp_err;
    logic [IOA_W-1:0]    r_io_addr;
    logic [CTRL_W-1:0]   r_io_ctrl;
    logic [N-1:0]        r_io_wdata;

    logic                w_accept;
    logic                w_gpr_addr_bad;

    // Request handshake; r_req_ready is only ever set in RUN/HALTED.
    assign w_accept       = bus.req_valid && r_req_ready;
    // GPR index lives in addr[4:0]; any upper bit set is out of range.
    assign w_gpr_addr_bad = (bus.req_addr[ADDR_W-1:5] != 7'd0);

    // Sequencer: state plus every output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_cmd       <= CMD_NOP;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_io_addr   <= '0;
            r_io_ctrl   <= CTRL_IDLE;
            r_io_wdata  <= '0;
        end else begin
            case (r_state)
                S_RUN, S_HALTED: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        // Latch the request; default outcome is an
                        // immediate clean response.
                        r_req_ready <= 1'b0;
                        r_cmd       <= bus.req_cmd;
                        r_io_addr   <= {3'b000, bus.req_addr};
                        r_io_wdata  <= bus.req_wdata;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        if (r_state == S_RUN) begin
                            // Core running: only halt/resume/nop are legal.
                            case (bus.req_cmd)
                                CMD_HALT:              r_io_ctrl <= CTRL_HALT;
                                CMD_NOP, CMD_RESUME:   r_io_ctrl <= CTRL_IDLE;
                                default:               r_rsp_err <= 1'b1;
                            endcase
                        end else begin
                            case (bus.req_cmd)
                                CMD_NOP, CMD_HALT: r_io_ctrl <= CTRL_HALT;
                                // Unhalt together with the response.
                                CMD_RESUME:        r_io_ctrl <= CTRL_IDLE;
                                CMD_READ_GPR: begin
                                    if (w_gpr_addr_bad) begin
                                        r_rsp_err <= 1'b1;
                                    end else begin
                                        r_rsp_valid <= 1'b0;
                                        r_io_ctrl   <= CTRL_RD_GPR;
                                        r_state     <= S_ACCESS;
                                    end
                                end
                                CMD_WRITE_GPR: begin
                                    if (w_gpr_addr_bad) begin
                                        r_rsp_err <= 1'b1;
                                    end else begin
                                        r_rsp_valid <= 1'b0;
                                        r_io_ctrl   <= CTRL_WR_GPR;
                                        r_state     <= S_ACCESS;
                                    end
                                end
                                CMD_READ_CSR: begin
                                    r_rsp_valid <= 1'b0;
                                    r_io_ctrl   <= CTRL_RD_CSR;
                                    r_state     <= S_ACCESS;
                                end
                                default:           r_rsp_err <= 1'b1;
                            endcase
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_cmd == CMD_WRITE_GPR) begin
                        // Register file commits on this edge; drop write enable.
                        r_io_ctrl   <= CTRL_HALT;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_state     <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    // Read data has had a full cycle to settle in the datapath.
                    r_rsp_rdata <= bus.coprocessorIODataIn;
                    r_io_ctrl   <= CTRL_HALT;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= r_io_ctrl[1] ? S_HALTED : S_RUN;
                    end
                end

                default: begin
                    r_state     <= S_RUN;
                    r_io_ctrl   <= CTRL_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Output drive.
    assign bus.req_ready            = r_req_ready;
    assign bus.rsp_valid            = r_rsp_valid;
    assign bus.rsp_rdata            = r_rsp_rdata;
    assign bus.rsp_err              = r_rsp_err;
    assign bus.halted               = r_io_ctrl[1];
    assign bus.coprocessorIOAddr    = r_io_addr;
    assign bus.coprocessorIOControl = r_io_ctrl;
    assign bus.coprocessorIODataOut = r_io_wdata;

endmodule

// File: tb/tb_debug_access_unit.sv
`timescale 1ns/1ps
module tb_debug_access_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    debug_access_unit_if #(.N(64)) bus ();

    debug_access_unit #(.N(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: 32-entry GPR file plus one CSR.
    logic [63:0] dp_regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) dp_regs[i] <= 64'd0;
        end else if (bus.coprocessorIOControl[0]) begin
            dp_regs[bus.coprocessorIOAddr[4:0]] <= bus.coprocessorIODataOut;
        end
    end

    always_comb begin
        bus.coprocessorIODataIn = 64'd0;
        if (bus.coprocessorIOControl[3]) begin
            if (bus.coprocessorIOAddr == 15'h305)
                bus.coprocessorIODataIn = 64'h8000_0100;
        end else begin
            bus.coprocessorIODataIn = dp_regs[bus.coprocessorIOAddr[4:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] cmd, input logic [11:0] addr, input logic [63:0] wd);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_send", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'd0;
        bus.req_addr  = 12'd0;
        bus.req_wdata = 64'd0;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'd0;
        bus.req_addr  = 12'd0;
        bus.req_wdata = 64'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_ctrl",      64'(bus.coprocessorIOControl), 64'd0);
        chk("rst_halted",    64'(bus.halted), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        // READ_GPR while running: rejected after one cycle, no control activity
        send(3'd3, 12'd5, 64'd0);
        chk("run_rd_valid", 64'(bus.rsp_valid), 64'd1);
        chk("run_rd_err",   64'(bus.rsp_err), 64'd1);
        chk("run_rd_ctrl",  64'(bus.coprocessorIOControl), 64'd0);
        chk("run_rd_rdata", bus.rsp_rdata, 64'd0);
        handshake();
        chk("run_rd_halted", 64'(bus.halted), 64'd0);
        chk("run_rd_ready",  64'(bus.req_ready), 64'd1);

        // HALT
        send(3'd1, 12'd0, 64'd0);
        chk("halt_valid",  64'(bus.rsp_valid), 64'd1);
        chk("halt_err",    64'(bus.rsp_err), 64'd0);
        chk("halt_halted", 64'(bus.halted), 64'd1);
        chk("halt_ctrl",   64'(bus.coprocessorIOControl), 64'h02);
        handshake();

        // WRITE_GPR x7: write enable for exactly one cycle
        send(3'd4, 12'd7, 64'hDEAD_BEEF);
        chk("wr_access_ctrl",  64'(bus.coprocessorIOControl), 64'h03);
        chk("wr_access_addr",  64'(bus.coprocessorIOAddr), 64'd7);
        chk("wr_access_wdata", bus.coprocessorIODataOut, 64'hDEAD_BEEF);
        chk("wr_access_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("wr_resp_ctrl",  64'(bus.coprocessorIOControl), 64'h02);
        chk("wr_resp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("wr_resp_err",   64'(bus.rsp_err), 64'd0);
        chk("wr_resp_rdata", bus.rsp_rdata, 64'd0);
        handshake();

        // READ_GPR x7: response on the third edge counting acceptance
        send(3'd3, 12'd7, 64'd0);
        chk("rd_c1_ctrl",  64'(bus.coprocessorIOControl), 64'h06);
        chk("rd_c1_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("rd_c2_ctrl",  64'(bus.coprocessorIOControl), 64'h06);
        chk("rd_c2_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("rd_c3_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rd_c3_rdata", bus.rsp_rdata, 64'hDEAD_BEEF);
        chk("rd_c3_err",   64'(bus.rsp_err), 64'd0);
        chk("rd_c3_ctrl",  64'(bus.coprocessorIOControl), 64'h02);
        handshake();

        // READ_CSR 0x305
        send(3'd5, 12'h305, 64'd0);
        chk("csr_c1_ctrl", 64'(bus.coprocessorIOControl), 64'h0E);
        chk("csr_c1_addr", 64'(bus.coprocessorIOAddr), 64'h305);
        @(negedge clk);
        chk("csr_c2_ctrl",  64'(bus.coprocessorIOControl), 64'h0E);
        chk("csr_c2_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("csr_valid", 64'(bus.rsp_valid), 64'd1);
        chk("csr_rdata", bus.rsp_rdata, 64'h8000_0100);
        chk("csr_err",   64'(bus.rsp_err), 64'd0);
        handshake();

        // Out-of-range GPR index: immediate error, no access cycle
        send(3'd3, 12'h020, 64'd0);
        chk("badidx_valid", 64'(bus.rsp_valid), 64'd1);
        chk("badidx_err",   64'(bus.rsp_err), 64'd1);
        chk("badidx_ctrl",  64'(bus.coprocessorIOControl), 64'h02);
        handshake();

        // Illegal command
        send(3'd7, 12'd0, 64'd0);
        chk("illegal_valid", 64'(bus.rsp_valid), 64'd1);
        chk("illegal_err",   64'(bus.rsp_err), 64'd1);
        handshake();

        // HALT twice while halted
        send(3'd1, 12'd0, 64'd0);
        chk("halt2a_err",    64'(bus.rsp_err), 64'd0);
        chk("halt2a_halted", 64'(bus.halted), 64'd1);
        handshake();
        send(3'd1, 12'd0, 64'd0);
        chk("halt2b_err",    64'(bus.rsp_err), 64'd0);
        chk("halt2b_halted", 64'(bus.halted), 64'd1);
        handshake();

        // Back-pressure on a GPR read
        send(3'd3, 12'd7, 64'd0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rdata", bus.rsp_rdata, 64'hDEAD_BEEF);
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_ctrl",  64'(bus.coprocessorIOControl), 64'h02);
            @(negedge clk);
        end
        handshake();
        chk("bp_after_ready", 64'(bus.req_ready), 64'd1);
        chk("bp_after_valid", 64'(bus.rsp_valid), 64'd0);

        // RESUME from halted: unhalted with the response
        send(3'd2, 12'd0, 64'd0);
        chk("resume_valid",  64'(bus.rsp_valid), 64'd1);
        chk("resume_err",    64'(bus.rsp_err), 64'd0);
        chk("resume_halted", 64'(bus.halted), 64'd0);
        chk("resume_ctrl",   64'(bus.coprocessorIOControl), 64'd0);
        handshake();

        // Reset during CAPTURE
        send(3'd1, 12'd0, 64'd0);
        handshake();
        send(3'd3, 12'd7, 64'd0);
        @(negedge clk);
        chk("pre_rst_capture_ctrl", 64'(bus.coprocessorIOControl), 64'h06);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl",   64'(bus.coprocessorIOControl), 64'd0);
        chk("midrst_halted", 64'(bus.halted), 64'd0);
        chk("midrst_valid",  64'(bus.rsp_valid), 64'd0);
        chk("midrst_rdata",  bus.rsp_rdata, 64'd0);
        chk("midrst_addr",   64'(bus.coprocessorIOAddr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("postrst_ready", 64'(bus.req_ready), 64'd1);
        send(3'd2, 12'd0, 64'd0);
        chk("postrst_resume_valid",  64'(bus.rsp_valid), 64'd1);
        chk("postrst_resume_err",    64'(bus.rsp_err), 64'd0);
        chk("postrst_resume_halted", 64'(bus.halted), 64'd0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_access_unit.md
Name: debug_access_unit

Overview:
- Sequencer sitting directly upstream of the core datapath's coprocessor I/O port; drives the `coprocessorIOAddr`, `coprocessorIOControl` and `coprocessorIODataOut` inputs and consumes `coprocessorIODataIn`.
- Converts valid/ready debug requests from the host command decoder into halt/resume, GPR read/write and CSR read sequences.
- Any nonzero `coprocessorIOControl` freezes the core PC, so this block owns core halting.

Parameters:
- N, 64, datapath/GPR/CSR data width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept request
- req_cmd  input  3  0 NOP, 1 HALT, 2 RESUME, 3 READ_GPR, 4 WRITE_GPR, 5 READ_CSR, 6-7 illegal
- req_addr  input  12  GPR index (bits 4:0) or CSR address
- req_wdata  input  N  GPR write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  host accepts response
- rsp_rdata  output  N  read data (0 for non-read commands)
- rsp_err  output  1  request rejected
- halted  output  1  core is held by this block
- coprocessorIOAddr  output  15  {3'b0, latched addr}
- coprocessorIOControl  output  5  [0] GPR write enable, [1] halt hold, [2] read active, [3] CSR select, [4] always 0
- coprocessorIODataOut  output  N  latched req_wdata
- coprocessorIODataIn  input  N  GPR/CSR read data from datapath

Behaviour:
- Reset (async, active-high) forces all outputs to 0 and state RUN. Any in-flight access or pending response is discarded.
- States: RUN, HALTED, ACCESS, CAPTURE, RESP.
- `req_ready` = 1 only in RUN or HALTED. A request is accepted on a clk edge with `req_valid` && `req_ready`. cmd, addr and wdata are latched on acceptance.
- RUN:
  - Control = 0.
  - HALT goes to RESP with err=0 and halted=1, and control[1]=1 from the next cycle onward.
  - RESUME or NOP goes to RESP with err=0.
  - READ_GPR, WRITE_GPR or READ_CSR goes to RESP with err=1, with no control activity.
  - Illegal cmd goes to RESP with err=1.
- HALTED:
  - control[1]=1 continuously.
  - HALT or NOP goes to RESP with err=0; HALT is idempotent.
  - RESUME goes to RESP with err=0. halted and control[1] clear in the same cycle `rsp_valid` rises.
  - For READ_GPR or WRITE_GPR, if addr[11:5] != 0, go to RESP with err=1. Otherwise go to ACCESS.
  - READ_CSR goes to ACCESS.
  - Illegal cmd goes to RESP with err=1.
- ACCESS (exactly 1 cycle):
  - `coprocessorIOAddr` holds the latched addr.
  - READ_GPR: control = 5'b00110.
  - READ_CSR: control = 5'b01110.
  - WRITE_GPR: control = 5'b00011, with `coprocessorIODataOut` = wdata. The register file commits on this cycle's closing edge.
  - Reads go to CAPTURE; writes go to RESP.
- CAPTURE (1 cycle):
  - Control and addr are unchanged from ACCESS.
  - `rsp_rdata` <= `coprocessorIODataIn` on the closing edge, then go to RESP.
- Access latency:
  - Read: acceptance edge to `rsp_valid` = 3 cycles.
  - Write: 2 cycles.
- RESP:
  - `rsp_valid`=1. rdata and err are stable until `rsp_valid` && `rsp_ready`, then return to HALTED if halted=1, else RUN.
  - During RESP after an access, control = 5'b00010 (halt only). Write enable is never asserted outside ACCESS.
  - The response after RESUME is returned with the core already running.
- rdata = 0 and err = 0 for HALT, RESUME, NOP and WRITE_GPR responses.
- GPR write to x0 is issued normally; the datapath discards it.
- `halted` is always equal to control[1].
- Back-pressure: `rsp_ready` held low keeps state RESP indefinitely. No new request is accepted meanwhile.

Test Plan:
- Reset, then READ_GPR addr 5 while running -> rsp_err=1 after 1 cycle; control stays 0 throughout; state RUN.
- HALT, then WRITE_GPR addr 7 wdata 0xDEAD_BEEF -> control=5'b00011 for exactly one cycle with IOAddr=7. A following READ_GPR 7 returns rsp_rdata=0xDEADBEEF, err=0, 3 cycles after acceptance.
- While halted, READ_CSR addr 0x305 with datapath returning 0x8000_0100 -> control=5'b01110 for 2 cycles, IOAddr=0x305, rsp_rdata=0x80000100.
- Halted, READ_GPR addr 0x020 -> err=1, no ACCESS cycle; cmd 7 -> err=1; HALT issued twice -> both err=0, halted stays 1.
- Halted, READ_GPR with rsp_ready held low for 5 cycles -> rsp_valid and rdata held, req_ready=0, control=5'b00010. After the handshake, req_ready=1.
- Reset asserted during CAPTURE -> all outputs 0 immediately, core unhalted, no response; RESUME after reset -> err=0.
